// File: rtl/render_pkg.sv
// Shared rendering definitions: screen geometry defaults, colour codes,
// frame scheduler state encoding and a small width helper.
package render_pkg;

    // vga_adapter port widths
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    // Default screen geometry for the clear sweep
    localparam int SCR_W_DEF = 160;
    localparam int SCR_H_DEF = 120;

    // Palette entries used by the render requesters and the clear sweep
    localparam logic [C_W-1:0] COLOUR_BG   = 3'b011;
    localparam logic [C_W-1:0] COLOUR_PIPE = 3'b110;
    localparam logic [C_W-1:0] COLOUR_BIRD = 3'b100;

    // Frame sequencing states
    typedef enum logic [1:0] {
        WAIT,
        CLEAR,
        DRAW,
        STEP
    } state_t;

    // $clog2 that never returns 0, so single-entry counters still get a bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pixel arbiter: picks one requester that has a pixel and has
// not finished its frame, searching upward from the pointer with wrap.
module rr_arbiter
    import render_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PTR_W = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] next_ptr,
    output logic             any_gnt
);

    logic [N_REQ-1:0] eligible;
    int               idx;

    // First eligible requester at or after ptr wins; pointer moves past it
    always_comb begin
        eligible = req & ~done;
        gnt      = '0;
        next_ptr = ptr;
        any_gnt  = 1'b0;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!any_gnt && eligible[idx]) begin
                gnt[idx] = 1'b1;
                next_ptr = PTR_W'((idx + 1) % N_REQ);
                any_gnt  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_draw_scheduler.sv
// Frame draw scheduler: sole owner of the vga_adapter write port. Each frame
// it sweeps the background colour over the screen, then lets the bird, pipe
// and score requesters draw through a round-robin arbiter, then issues one
// game-step pulse so the datapath only changes state between frames.
module frame_draw_scheduler
    import render_pkg::*;
#(
    parameter int             N_REQ        = 3,
    parameter int             SCR_W        = SCR_W_DEF,
    parameter int             SCR_H        = SCR_H_DEF,
    parameter int             FRAME_CYCLES = 833333,
    parameter logic [C_W-1:0] CLEAR_COLOUR = COLOUR_BG
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [N_REQ-1:0]       active,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_last,
    input  logic [X_W*N_REQ-1:0]   req_x,
    input  logic [Y_W*N_REQ-1:0]   req_y,
    input  logic [C_W*N_REQ-1:0]   req_colour,
    output logic [N_REQ-1:0]       gnt,
    output logic                   plot,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [C_W-1:0]         colour,
    output logic                   frame_start,
    output logic                   step,
    output logic                   busy,
    output logic                   overrun
);

    localparam int CX_W  = clog2_min1(SCR_W);
    localparam int CY_W  = clog2_min1(SCR_H);
    localparam int FC_W  = clog2_min1(FRAME_CYCLES);
    localparam int PTR_W = clog2_min1(N_REQ);

    localparam logic [CX_W-1:0] CX_LAST = CX_W'(SCR_W - 1);
    localparam logic [CY_W-1:0] CY_LAST = CY_W'(SCR_H - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_CYCLES - 1);

    state_t             state;
    state_t             next_state;

    logic [FC_W-1:0]    frame_cnt;
    logic [CX_W-1:0]    clear_x;
    logic [CY_W-1:0]    clear_y;
    logic [N_REQ-1:0]   done;
    logic [N_REQ-1:0]   done_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic               pending;

    logic               boundary;
    logic               clear_last;
    logic               start_frame;
    logic               in_draw;

    logic [N_REQ-1:0]   arb_gnt;
    logic [N_REQ-1:0]   draw_gnt;
    logic [PTR_W-1:0]   arb_next_ptr;
    logic               arb_any;
    logic               draw_any;

    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [C_W-1:0]     sel_colour;

    assign boundary   = (frame_cnt == FC_LAST);
    assign clear_last = (clear_x == CX_LAST) && (clear_y == CY_LAST);
    assign in_draw    = (state == DRAW);
    assign draw_gnt   = in_draw ? arb_gnt : '0;
    assign draw_any   = in_draw && arb_any;
    assign done_next  = done | (draw_gnt & req_last);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req      (req),
        .done     (done),
        .ptr      (rr_ptr),
        .gnt      (arb_gnt),
        .next_ptr (arb_next_ptr),
        .any_gnt  (arb_any)
    );

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            state <= WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start_frame marks every entry into CLEAR
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        next_state  = state;
        start_frame = 1'b0;
        case (state)
            WAIT: begin
                if (boundary || pending) begin
                    next_state  = CLEAR;
                    start_frame = 1'b1;
                end
            end
            CLEAR: begin
                if (clear_last) begin
                    next_state = DRAW;
                end
            end
            DRAW: begin
                if (&done_next) begin
                    next_state = STEP;
                end
            end
            STEP: begin
                // A boundary landing here is already late; skip WAIT entirely
                if (pending || boundary) begin
                    next_state  = CLEAR;
                    start_frame = 1'b1;
                end else begin
                    next_state = WAIT;
                end
            end
            default: next_state = WAIT;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        frame_start = start_frame;
        busy        = (state != WAIT);
        step        = (state == STEP) && enable;
        gnt         = draw_gnt;
    end

    // Free-running frame timer; wraps on the boundary value
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_cnt <= '0;
        end else if (boundary) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + FC_W'(1);
        end
    end

    // Clear sweep raster position: x inner, y outer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clear_x <= '0;
            clear_y <= '0;
        end else if (start_frame) begin
            clear_x <= '0;
            clear_y <= '0;
        end else if (state == CLEAR) begin
            if (clear_x == CX_LAST) begin
                clear_x <= '0;
                clear_y <= (clear_y == CY_LAST) ? '0 : clear_y + CY_W'(1);
            end else begin
                clear_x <= clear_x + CX_W'(1);
            end
        end
    end

    // Per-frame done mask and round-robin pointer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            done   <= '1;
            rr_ptr <= '0;
        end else begin
            if (start_frame) begin
                // Inactive requesters are treated as already finished
                done <= ~active;
            end else if (in_draw) begin
                done <= done_next;
            end
            if (draw_any) begin
                rr_ptr <= arb_next_ptr;
            end
        end
    end

    // Late-frame tracking: a boundary while busy queues the next frame
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (start_frame) begin
                pending <= 1'b0;
            end else if (boundary && busy) begin
                pending <= 1'b1;
            end
            if (boundary && busy) begin
                overrun <= 1'b1;
            end
        end
    end

    // Select the granted requester's pixel fields
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_x      = req_x[X_W*i +: X_W];
                sel_y      = req_y[Y_W*i +: Y_W];
                sel_colour = req_colour[C_W*i +: C_W];
            end
        end
    end

    // Registered vga_adapter write port; address and colour hold between writes
    always_ff @(posedge clk) begin
        if (!resetn) begin
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else begin
            plot <= 1'b0;
            if (state == CLEAR) begin
                plot   <= 1'b1;
                x      <= X_W'(clear_x);
                y      <= Y_W'(clear_y);
                colour <= CLEAR_COLOUR;
            end else if (draw_any) begin
                plot   <= 1'b1;
                x      <= sel_x;
                y      <= sel_y;
                colour <= sel_colour;
            end
        end
    end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Directed bench for frame_draw_scheduler on a 4x2 screen with 64-cycle frames.
// Inputs change 1 time unit after the rising edge; outputs are read on the
// falling edge. A small requester model feeds pixels and advances on gnt.
module tb_frame_draw_scheduler;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         enable = 1'b0;
    logic [2:0]   active = '0;
    logic [2:0]   req = '0;
    logic [2:0]   req_last = '0;
    logic [23:0]  req_x = '0;
    logic [20:0]  req_y = '0;
    logic [8:0]   req_colour = '0;
    logic [2:0]   gnt;
    logic         plot;
    logic [7:0]   x;
    logic [6:0]   y;
    logic [2:0]   colour;
    logic         frame_start;
    logic         step;
    logic         busy;
    logic         overrun;

    always #5 clk = ~clk;

    frame_draw_scheduler #(
        .N_REQ        (3),
        .SCR_W        (4),
        .SCR_H        (2),
        .FRAME_CYCLES (64),
        .CLEAR_COLOUR (3'b011)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .active      (active),
        .req         (req),
        .req_last    (req_last),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_colour  (req_colour),
        .gnt         (gnt),
        .plot        (plot),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .frame_start (frame_start),
        .step        (step),
        .busy        (busy),
        .overrun     (overrun)
    );

    int checks = 0;
    int passes = 0;

    // Sampled outputs from the most recent falling edge
    logic [2:0] gnt_s;
    logic       plot_s, busy_s, ov_s, fs_s, step_s;
    logic [7:0] x_s;
    logic [6:0] y_s;
    logic [2:0] c_s;

    // Per-run log
    int cyc;
    int plot_n;
    int plot_xv[64];
    int plot_yv[64];
    int plot_cv[64];
    int plot_cyc[64];
    int gnt_log[$];
    int step_n, step_cyc, fs_n, fs_cyc;

    // Requester model state
    int npix[N];
    int sent[N];
    int stall_cnt = 0;
    bit arm_stall = 1'b0;

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req[i]                = (sent[i] < npix[i]) && !(i == 0 && stall_cnt > 0);
            req_last[i]           = (sent[i] == npix[i] - 1);
            req_x[8*i +: 8]       = 8'(10 * i + sent[i]);
            req_y[7*i +: 7]       = 7'(i + 1);
            req_colour[3*i +: 3]  = 3'(i + 4);
        end
    endtask

    task automatic clear_log();
        cyc      = 0;
        plot_n   = 0;
        gnt_log.delete();
        step_n   = 0;
        step_cyc = -1;
        fs_n     = 0;
        fs_cyc   = -1;
    endtask

    // One clock: sample at negedge, then advance the requesters after the edge
    task automatic cycle();
        @(negedge clk);
        gnt_s  = gnt;
        plot_s = plot;
        busy_s = busy;
        ov_s   = overrun;
        fs_s   = frame_start;
        step_s = step;
        x_s    = x;
        y_s    = y;
        c_s    = colour;
        if (plot && plot_n < 64) begin
            plot_xv[plot_n]  = int'(x);
            plot_yv[plot_n]  = int'(y);
            plot_cv[plot_n]  = int'(colour);
            plot_cyc[plot_n] = cyc;
            plot_n++;
        end
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) gnt_log.push_back(i);
        end
        if (step) begin
            if (step_n == 0) step_cyc = cyc;
            step_n++;
        end
        if (frame_start) begin
            if (fs_n == 0) fs_cyc = cyc;
            fs_n++;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (fs_s) begin
            for (int i = 0; i < N; i++) sent[i] = 0;
        end
        if (fs_s && arm_stall) begin
            stall_cnt = 68;
            arm_stall = 1'b0;
        end else if (stall_cnt > 0) begin
            stall_cnt--;
        end
        for (int i = 0; i < N; i++) begin
            if (gnt_s[i]) sent[i]++;
        end
        drive_reqs();
    endtask

    // Run until a frame has gone busy and returned to idle
    task automatic run_frame(input bit do_clear);
        bit seen = 1'b0;
        bit ok   = 1'b0;
        if (do_clear) clear_log();
        for (int n = 0; n < 300; n++) begin
            cycle();
            if (busy_s) seen = 1'b1;
            else if (seen) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) $display("FAIL frame_complete: busy_seen=%0d, frame did not return to idle within 300 cycles", seen);
        else passes++;
    endtask

    task automatic wait_fs(input int budget);
        for (int n = 0; n < budget; n++) begin
            cycle();
            if (fs_s) break;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        enable = 1'b1;
        active = 3'b111;
        npix   = '{5, 5, 5};
        drive_reqs();
        repeat (3) cycle();
        checks++;
        if ({plot_s, gnt_s, busy_s, ov_s, step_s, fs_s} !== 8'b0)
            $display("FAIL reset_ctrl: got {plot,gnt,busy,ovr,step,fs}=%b, expected 00000000",
                     {plot_s, gnt_s, busy_s, ov_s, step_s, fs_s});
        else passes++;
        checks++;
        if ({x_s, y_s, c_s} !== 18'b0)
            $display("FAIL reset_pixel: got x=%0d y=%0d colour=%0d, expected 0 0 0", x_s, y_s, c_s);
        else passes++;
        active = 3'b000;
        npix   = '{0, 0, 0};
        drive_reqs();
    endtask

    task automatic test_first_frame();
        resetn = 1'b1;
        clear_log();
        run_frame(1'b0);
        checks++;
        if (fs_cyc !== 63) $display("FAIL first_frame_start: got cycle %0d, expected 63", fs_cyc);
        else passes++;
        checks++;
        if (plot_n !== 8) $display("FAIL clear_count: got %0d plots, expected 8", plot_n);
        else passes++;
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (plot_xv[j] !== j % 4 || plot_yv[j] !== j / 4 || plot_cv[j] !== 3)
                $display("FAIL clear_px%0d: got (%0d,%0d) c=%0d, expected (%0d,%0d) c=3",
                         j, plot_xv[j], plot_yv[j], plot_cv[j], j % 4, j / 4);
            else passes++;
        end
        checks++;
        if (plot_cyc[0] !== 65) $display("FAIL clear_latency: first plot at cycle %0d, expected 65", plot_cyc[0]);
        else passes++;
        checks++;
        if (step_n !== 1 || step_cyc !== 73)
            $display("FAIL first_step: got %0d pulses first at %0d, expected 1 at 73", step_n, step_cyc);
        else passes++;
    endtask

    task automatic test_grant_order();
        int  exp_g[6] = '{0, 1, 2, 0, 1, 2};
        bit  bad = 1'b0;
        active = 3'b111;
        npix   = '{2, 2, 2};
        drive_reqs();
        run_frame(1'b1);
        if (gnt_log.size() != 6) bad = 1'b1;
        else for (int j = 0; j < 6; j++) if (gnt_log[j] != exp_g[j]) bad = 1'b1;
        checks++;
        if (bad) $display("FAIL grant_order: got %0d grants %p, expected 0,1,2,0,1,2", gnt_log.size(), gnt_log);
        else passes++;
        checks++;
        if (plot_n !== 14) $display("FAIL draw_plot_count: got %0d, expected 14", plot_n);
        else passes++;
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (plot_xv[8+j] !== 10 * (j % 3) + j / 3 || plot_yv[8+j] !== j % 3 + 1 || plot_cv[8+j] !== j % 3 + 4)
                $display("FAIL draw_px%0d: got (%0d,%0d) c=%0d, expected (%0d,%0d) c=%0d", j,
                         plot_xv[8+j], plot_yv[8+j], plot_cv[8+j], 10 * (j % 3) + j / 3, j % 3 + 1, j % 3 + 4);
            else passes++;
        end
        checks++;
        if (step_n !== 1) $display("FAIL grant_step: got %0d step pulses, expected 1", step_n);
        else passes++;
    endtask

    task automatic test_inactive();
        int  exp_g[4] = '{0, 2, 0, 2};
        bit  bad = 1'b0;
        active = 3'b101;
        npix   = '{2, 100, 2};
        drive_reqs();
        run_frame(1'b1);
        if (gnt_log.size() != 4) bad = 1'b1;
        else for (int j = 0; j < 4; j++) if (gnt_log[j] != exp_g[j]) bad = 1'b1;
        checks++;
        if (bad) $display("FAIL inactive_grants: got %0d grants %p, expected 0,2,0,2", gnt_log.size(), gnt_log);
        else passes++;
        checks++;
        if (step_n !== 1) $display("FAIL inactive_step: got %0d step pulses, expected 1", step_n);
        else passes++;
    endtask

    task automatic test_enable();
        enable = 1'b0;
        active = 3'b111;
        npix   = '{1, 1, 1};
        drive_reqs();
        run_frame(1'b1);
        checks++;
        if (plot_n !== 11 || gnt_log.size() != 3)
            $display("FAIL disabled_render: got %0d plots %0d grants, expected 11 plots 3 grants", plot_n, gnt_log.size());
        else passes++;
        checks++;
        if (step_n !== 0) $display("FAIL disabled_step: got %0d step pulses, expected 0", step_n);
        else passes++;
        enable = 1'b1;
        run_frame(1'b1);
        checks++;
        if (step_n !== 1) $display("FAIL enabled_step: got %0d step pulses, expected 1", step_n);
        else passes++;
    endtask

    // Requester 0 stalls for the 8 clear cycles plus 60 draw cycles
    task automatic test_overrun();
        logic ov64 = 1'bx;
        logic ov65 = 1'bx;
        int   fs_k = -1;
        int   gap  = 0;
        active    = 3'b111;
        npix      = '{1, 1, 1};
        enable    = 1'b1;
        arm_stall = 1'b1;
        drive_reqs();
        clear_log();
        wait_fs(100);
        checks++;
        if (!fs_s) $display("FAIL overrun_start: frame_start got 0, expected 1 within 100 cycles");
        else passes++;
        step_n = 0;
        for (int k = 1; k <= 90; k++) begin
            cycle();
            if (k == 64) ov64 = ov_s;
            if (k == 65) ov65 = ov_s;
            if (fs_s && fs_k < 0) fs_k = k;
            if (k <= 82 && !busy_s) gap++;
        end
        checks++;
        if (ov64 !== 1'b0) $display("FAIL overrun_early: got %b before boundary, expected 0", ov64);
        else passes++;
        checks++;
        if (ov65 !== 1'b1) $display("FAIL overrun_set: got %b after boundary, expected 1", ov65);
        else passes++;
        checks++;
        if (fs_k !== 70) $display("FAIL overrun_restart: frame_start at %0d, expected 70", fs_k);
        else passes++;
        checks++;
        if (gap !== 0) $display("FAIL overrun_no_wait: got %0d idle cycles, expected 0", gap);
        else passes++;
        checks++;
        if (step_n !== 2) $display("FAIL overrun_steps: got %0d step pulses, expected 2", step_n);
        else passes++;
        checks++;
        if (ov_s !== 1'b1) $display("FAIL overrun_sticky: got %b, expected 1", ov_s);
        else passes++;
    endtask

    task automatic test_reset_mid();
        active = 3'b111;
        npix   = '{3, 3, 3};
        drive_reqs();
        clear_log();
        wait_fs(100);
        for (int k = 1; k <= 10; k++) cycle();
        checks++;
        if (gnt_s === 3'b000) $display("FAIL mid_draw_gnt: got gnt=%b, expected a grant", gnt_s);
        else passes++;
        resetn = 1'b0;
        cycle();
        cycle();
        checks++;
        if ({plot_s, gnt_s, busy_s, ov_s, step_s} !== 7'b0)
            $display("FAIL mid_reset: got {plot,gnt,busy,ovr,step}=%b, expected 0000000",
                     {plot_s, gnt_s, busy_s, ov_s, step_s});
        else passes++;
        resetn = 1'b1;
        clear_log();
        wait_fs(100);
        checks++;
        if (fs_cyc !== 63) $display("FAIL restart_start: got cycle %0d, expected 63", fs_cyc);
        else passes++;
    endtask

    initial begin
        npix = '{0, 0, 0};
        sent = '{0, 0, 0};
        drive_reqs();
        test_reset();
        test_first_frame();
        test_grant_order();
        test_inactive();
        test_enable();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
